// File: rtl/mult_u_iter_resid_if.sv
// Operand/result bus for the iterative residue-checked multiplier.
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. The producer keeps valid and its payload stable until that
// edge. The consumer may change ready at any time. On the input side the
// block raises in_ready only while it is idle. On the output side it holds
// p/err/retried stable for as long as out_valid is high.
`timescale 1ns/1ps
interface mult_u_iter_resid_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 err;
    logic                 retried;
    logic                 flt_en;
    logic [2*WIDTH-1:0]   flt_mask;

    modport master (
        output in_valid, a, b, out_ready, flt_en, flt_mask,
        input  in_ready, out_valid, p, err, retried
    );

    modport slave (
        input  in_valid, a, b, out_ready, flt_en, flt_mask,
        output in_ready, out_valid, p, err, retried
    );
endinterface

// File: rtl/mult_u_iter_resid.sv
// Unsigned WIDTH x WIDTH radix-2 shift-add multiplier. Every product is
// checked with a mod-3 residue. A mismatch triggers up to RETRY_MAX full
// recomputes before the result is flagged with err. Any single-bit flip in the
// product is detected. Error patterns whose net value change is a multiple of
// 3 pass through undetected.
`timescale 1ns/1ps
module mult_u_iter_resid #(
    parameter int WIDTH     = 4,
    parameter int RETRY_MAX = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_u_iter_resid_if.slave    bus,
    output logic [1:0]            dbg_state
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [PW-1:0]     a_sh_q, a_sh_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     acc_step;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        rcnt_q, rcnt_d;
    logic [1:0]        ra_q, ra_d, rb_q, rb_d;
    logic [1:0]        res_acc, res_exp;
    logic              err_q, err_d;
    logic              retried_q, retried_d;

    // Residues of the finished accumulator and of the captured operands.
    always_comb begin
        res_acc  = 2'(acc_q % PW'(3));
        res_exp  = 2'((4'(ra_q) * 4'(rb_q)) % 4'd3);
        acc_step = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;
    end

    // State register and datapath flops. Reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            err_q     <= 1'b0;
            retried_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            err_q     <= err_d;
            retried_q <= retried_d;
        end
    end

    // Next-state and datapath control: accept, iterate, check/retry, present.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        err_d     = err_q;
        retried_d = retried_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    a_sh_d    = {{WIDTH{1'b0}}, bus.a};
                    b_sh_d    = bus.b;
                    acc_d     = '0;
                    cnt_d     = '0;
                    rcnt_d    = '0;
                    ra_d      = 2'(bus.a % WIDTH'(3));
                    rb_d      = 2'(bus.b % WIDTH'(3));
                    err_d     = 1'b0;
                    retried_d = 1'b0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_step;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = CHECK;
                    // Fault injection only lands on the final accumulator write.
                    if (bus.flt_en) begin
                        acc_d = acc_step ^ bus.flt_mask;
                    end
                end
            end
            CHECK: begin
                if (res_acc == res_exp) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (rcnt_q != 2'(RETRY_MAX)) begin
                    rcnt_d    = rcnt_q + 2'd1;
                    retried_d = 1'b1;
                    a_sh_d    = {{WIDTH{1'b0}}, a_q};
                    b_sh_d    = b_q;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
                end else begin
                    // Out of retries: present the faulty product as-is.
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result fields are forced to zero outside DONE, so no partial value is ever shown.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
        bus.p         = (state_q == DONE) ? acc_q : '0;
        bus.err       = (state_q == DONE) && err_q;
        bus.retried   = (state_q == DONE) && retried_q;
        dbg_state     = state_q;
    end
endmodule

// File: doc/mult_u_iter_resid.md
Name: mult_u_iter_resid

Overview:
- Parametrised, sequential, unsigned WIDTH x WIDTH multiplier; successor to the fixed 4-bit combinational fault-resilient multipliers.
- Iterative radix-2 shift-add datapath with valid/ready handshakes on input and output.
- Mod-3 residue check on every product, with bounded automatic recompute on mismatch and an error flag when retries are exhausted.
- Fault-injection port lets the bench exercise the detection path.

Parameters:
- WIDTH, 4, operand width in bits; legal range >= 2.
- RETRY_MAX, 1, maximum recomputes after a residue mismatch; legal range 0..3.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b are valid.
- in_ready  out  1  block accepts operands; high only in IDLE and never while rst=1.
- a  in  WIDTH  unsigned multiplicand.
- b  in  WIDTH  unsigned multiplier.
- out_valid  out  1  p, err and retried are valid.
- out_ready  in  1  consumer accepts the result.
- p  out  2*WIDTH  product.
- err  out  1  residue mismatch persisted after RETRY_MAX recomputes.
- retried  out  1  at least one recompute occurred for this result.
- flt_en  in  1  fault-injection enable; verification only, tie 0 in product.
- flt_mask  in  2*WIDTH  XOR mask applied to the accumulator when flt_en=1.

Behaviour:
- Reset: state=IDLE; in_ready=0 while rst=1; out_valid=0, p=0, err=0, retried=0.
- Reset also clears the accumulator, shift registers, bit counter and retry counter.
- Reset asserted in any state abandons the operation; no partial result is ever presented.

- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a and b into operand registers.
  - Load a_sh = zero-extended a (2*WIDTH bits), b_sh = b, acc = 0, cnt = 0, rcnt = 0.
  - Register ra = a mod 3 and rb = b mod 3.
  - Go to CALC.
- State CALC, one iteration per cycle:
  - If b_sh[0]=1, acc <= acc + a_sh. The addition is 2*WIDTH bits wide and cannot overflow.
  - a_sh <<= 1; b_sh >>= 1; cnt++.
  - After exactly WIDTH cycles go to CHECK.
  - On the CALC->CHECK edge: if flt_en=1, acc <= (final acc) ^ flt_mask; otherwise acc is unchanged.
  - flt_en is sampled only on that edge.
- State CHECK, 1 cycle:
  - Compare acc mod 3 against (ra*rb) mod 3.
  - Match: go to DONE with err=0.
  - Mismatch and rcnt < RETRY_MAX: rcnt++, set retried=1, reload a_sh, b_sh and acc=0 from the captured operands, return to CALC.
  - Mismatch and rcnt = RETRY_MAX: go to DONE with err=1. p carries the faulty acc unchanged.
- State DONE:
  - out_valid=1.
  - p, err and retried are held stable until out_ready=1.
  - On out_valid & out_ready: go to IDLE, drop out_valid. in_ready rises the next cycle; no same-cycle re-accept.
- Latency, no retry:
  - Accept on edge k gives out_valid high after edge k+WIDTH+1.
  - Each retry adds WIDTH+1 cycles.
  - Throughput: one operation per WIDTH+3 cycles at best (accept, CALC, CHECK, DONE handshake).
- Residue coverage:
  - Any single-bit flip changes the value by ±2^i, which is never ≡ 0 mod 3, so it is always detected.
  - Error patterns whose net value change is a multiple of 3 are undetected. This limitation is accepted and documented.
- Inputs a and b are ignored outside the IDLE accept cycle.
- out_ready is ignored outside DONE.
- in_valid may drop before acceptance without effect.
- 0 operands are legal: the product is 0, with the full WIDTH iterations still executed.

Test Plan:
- WIDTH=4, accept a=13, b=11, out_ready=1 -> out_valid after edge k+5; p=143, err=0, retried=0.
- WIDTH=4, a=15, b=15, then a=0, b=9 back-to-back with in_valid held high -> p=225, then p=0; second accept occurs no earlier than the cycle after the first DONE handshake.
- RETRY_MAX=1, a=13, b=11, flt_en=1 with flt_mask=0x01 on the first CALC->CHECK edge only -> out_valid after edge k+10; p=143, err=0, retried=1.
- RETRY_MAX=0, same stimulus -> p=142, err=1, retried=0. Also flt_mask=0x03 -> p=140, err=0, demonstrating the undetected case.
- Backpressure: out_ready=0 for 7 cycles in DONE -> p, err and retried remain stable, in_ready=0 throughout; release gives exactly one handshake.
- rst=1 for one cycle at CALC cycle 2 of a=7, b=9 -> all outputs 0 next cycle; in_ready=1 the cycle after rst falls; no result for a=7, b=9 is emitted. A new a=3, b=5 then gives p=15.
- Exhaustive WIDTH=4 (256 pairs) plus random WIDTH=8 and WIDTH=16 -> p = a*b and err=0 for every pair.
